serv_csr_irq: RTL and testbench

//  Bit-serial machine-mode CSR/interrupt unit for the serv core, next generation of the timer-only CSR block.

---
 rtl/serv_irq_pkg.sv | 43 ++++
 rtl/serv_irq_arb.sv | 79 +++++++
 rtl/serv_csr_irq.sv | 120 ++++++++++++
 tb/tb_serv_csr_irq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_irq_pkg.sv
// Shared CSR selectors, write-source encodings, cause codes and bit positions
// for the serv machine-mode CSR/interrupt unit.
package serv_irq_pkg;

  typedef enum logic [1:0] {
    CSR_SOURCE_CSR = 2'd0,
    CSR_SOURCE_EXT = 2'd1,
    CSR_SOURCE_SET = 2'd2,
    CSR_SOURCE_CLR = 2'd3
  } csr_source_e;

  typedef enum logic [1:0] {
    CSR_SEL_MSTATUS = 2'd0,
    CSR_SEL_MIE     = 2'd1,
    CSR_SEL_MIP     = 2'd2,
    CSR_SEL_MCAUSE  = 2'd3
  } csr_sel_e;

  localparam logic [4:0] CAUSE_MSI       = 5'd3;
  localparam logic [4:0] CAUSE_MTI       = 5'd7;
  localparam logic [4:0] CAUSE_MEI       = 5'd11;
  localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

  localparam logic [4:0] EXC_JUMP  = 5'd0;
  localparam logic [4:0] EXC_BREAK = 5'd3;
  localparam logic [4:0] EXC_LOAD  = 5'd4;
  localparam logic [4:0] EXC_STORE = 5'd6;
  localparam logic [4:0] EXC_ECALL = 5'd11;

  localparam int unsigned BIT_MIE  = 3;
  localparam int unsigned BIT_MPIE = 7;
  localparam int unsigned BIT_MSI  = 3;
  localparam int unsigned BIT_MTI  = 7;
  localparam int unsigned BIT_MEI  = 11;

  function automatic logic [4:0] exc_code(input logic e_op, input logic ebreak,
                                          input logic mem_op, input logic mem_cmd);
    if (mem_op)    return mem_cmd ? EXC_STORE : EXC_LOAD;
    else if (e_op) return ebreak ? EXC_BREAK : EXC_ECALL;
    else           return EXC_JUMP;
  endfunction

endpackage

// File: rtl/serv_irq_arb.sv
// Interrupt pending logic: edge/level platform lines, mip assembly and
// fixed-priority selection of the highest enabled pending cause.
module serv_irq_arb
  import serv_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 1,
  parameter logic [15:0] IRQ_EDGE = 16'h0000
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_msip,
  input  logic                                 i_mtip,
  input  logic                                 i_meip,
  input  logic [(NUM_IRQ > 0 ? NUM_IRQ : 1)-1:0] i_irq,
  input  logic [31:0]                          i_mie,
  input  logic                                 i_clr,
  input  logic [4:0]                           i_clr_code,
  output logic [31:0]                          o_mip,
  output logic                                 o_any,
  output logic [4:0]                           o_code
);

  localparam int unsigned IW = (NUM_IRQ > 0) ? NUM_IRQ : 1;

  logic [IW-1:0] pend;
  logic [31:0]   en;

  if (NUM_IRQ > 0) begin : g_plat
    logic [IW-1:0] irq_q;
    logic [IW-1:0] pend_e;

    // A fresh rising edge wins over a same-cycle clear from the trap.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        irq_q  <= '0;
        pend_e <= '0;
      end else begin
        irq_q <= i_irq;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
          if (i_irq[k] & ~irq_q[k])
            pend_e[k] <= 1'b1;
          else if (i_clr && (i_clr_code == 5'(CAUSE_PLAT_BASE + k)))
            pend_e[k] <= 1'b0;
        end
      end
    end

    always_comb begin
      pend = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++)
        pend[k] = IRQ_EDGE[k] ? pend_e[k] : i_irq[k];
    end
  end else begin : g_noplat
    assign pend = '0;
  end

  always_comb begin
    o_mip          = '0;
    o_mip[BIT_MSI] = i_msip;
    o_mip[BIT_MTI] = i_mtip;
    o_mip[BIT_MEI] = i_meip;
    for (int unsigned k = 0; k < NUM_IRQ; k++)
      o_mip[16+k] = pend[k];
  end

  assign en    = o_mip & i_mie;
  assign o_any = |en;

  // Assign lowest priority first so the highest-priority hit lands last.
  always_comb begin
    o_code = '0;
    for (int unsigned k = NUM_IRQ; k > 0; k--)
      if (en[15+k]) o_code = 5'(15 + k);
    if (en[BIT_MTI]) o_code = CAUSE_MTI;
    if (en[BIT_MSI]) o_code = CAUSE_MSI;
    if (en[BIT_MEI]) o_code = CAUSE_MEI;
  end

endmodule

// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR/interrupt unit: mstatus, mie, mip, mcause,
// serial read/modify/write and interrupt acceptance towards the core.
module serv_csr_irq
  import serv_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 1,
  parameter logic [15:0] IRQ_EDGE = 16'h0000
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic [4:0]                           i_cnt,
  input  logic                                 i_cnt_done,
  input  logic                                 i_init,
  input  logic                                 i_trap,
  input  logic                                 i_mret,
  input  logic                                 i_e_op,
  input  logic                                 i_ebreak,
  input  logic                                 i_mem_op,
  input  logic                                 i_mem_cmd,
  input  logic [1:0]                           i_csr_sel,
  input  logic                                 i_csr_en,
  input  logic [1:0]                           i_csr_source,
  input  logic                                 i_csr_d,
  input  logic                                 i_msip,
  input  logic                                 i_mtip,
  input  logic                                 i_meip,
  input  logic [(NUM_IRQ > 0 ? NUM_IRQ : 1)-1:0] i_irq,
  output logic                                 o_csr_in,
  output logic                                 o_q,
  output logic                                 o_new_irq
);

  localparam logic [31:0] PLAT_MASK    = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0888 | PLAT_MASK;
  localparam logic [31:0] MCAUSE_MASK  = 32'h8000_001F;

  logic [31:0] mstatus_q, mie_q, mcause_q, mip, csr_word;
  logic [4:0]  irq_code, sel_code;
  logic        irq_any, trap_done, csr_we;
  csr_sel_e    sel;
  csr_source_e src;

  assign sel       = csr_sel_e'(i_csr_sel);
  assign src       = csr_source_e'(i_csr_source);
  assign trap_done = i_trap & i_cnt_done;
  assign csr_we    = i_csr_en & i_en & ~i_trap;

  serv_irq_arb #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_msip     (i_msip),
    .i_mtip     (i_mtip),
    .i_meip     (i_meip),
    .i_irq      (i_irq),
    .i_mie      (mie_q),
    .i_clr      (trap_done & o_new_irq),
    .i_clr_code (irq_code),
    .o_mip      (mip),
    .o_any      (irq_any),
    .o_code     (sel_code)
  );

  always_comb begin
    case (sel)
      CSR_SEL_MSTATUS: csr_word = mstatus_q;
      CSR_SEL_MIE:     csr_word = mie_q;
      CSR_SEL_MIP:     csr_word = mip;
      default:         csr_word = mcause_q;
    endcase
    o_q = csr_word[i_cnt];
    case (src)
      CSR_SOURCE_EXT: o_csr_in = i_csr_d;
      CSR_SOURCE_SET: o_csr_in = o_q | i_csr_d;
      CSR_SOURCE_CLR: o_csr_in = o_q & ~i_csr_d;
      default:        o_csr_in = o_q;
    endcase
  end

  // Unimplemented bits are held at zero by masking every serial write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mcause_q  <= '0;
      irq_code  <= '0;
      o_new_irq <= 1'b0;
    end else begin
      if (csr_we) begin
        case (sel)
          CSR_SEL_MSTATUS: mstatus_q[i_cnt] <= o_csr_in & MSTATUS_MASK[i_cnt];
          CSR_SEL_MIE:     mie_q[i_cnt]     <= o_csr_in & MIE_MASK[i_cnt];
          CSR_SEL_MCAUSE:  mcause_q[i_cnt]  <= o_csr_in & MCAUSE_MASK[i_cnt];
          default: ;
        endcase
      end
      if (trap_done) begin
        mstatus_q[BIT_MPIE] <= mstatus_q[BIT_MIE];
        mstatus_q[BIT_MIE]  <= 1'b0;
        mcause_q  <= {o_new_irq, 26'd0,
                      o_new_irq ? irq_code : exc_code(i_e_op, i_ebreak, i_mem_op, i_mem_cmd)};
        o_new_irq <= 1'b0;
      end else begin
        if (i_mret & i_cnt_done) begin
          mstatus_q[BIT_MIE]  <= mstatus_q[BIT_MPIE];
          mstatus_q[BIT_MPIE] <= 1'b1;
        end
        if (i_cnt_done & ~i_init & ~o_new_irq & mstatus_q[BIT_MIE] & irq_any) begin
          o_new_irq <= 1'b1;
          irq_code  <= sel_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_csr_irq.sv
// Directed and randomized checks of serv_csr_irq against a word-level
// behavioural model of the machine-mode CSRs and interrupt acceptance.
module tb_serv_csr_irq;

  localparam int unsigned NIRQ = 2;

  logic            i_clk = 1'b0;
  logic            i_rst, i_en, i_cnt_done, i_init, i_trap, i_mret;
  logic            i_e_op, i_ebreak, i_mem_op, i_mem_cmd, i_csr_en, i_csr_d;
  logic            i_msip, i_mtip, i_meip;
  logic [4:0]      i_cnt;
  logic [1:0]      i_csr_sel, i_csr_source;
  logic [NIRQ-1:0] i_irq;
  logic            o_csr_in, o_q, o_new_irq;

  serv_csr_irq #(
    .NUM_IRQ  (NIRQ),
    .IRQ_EDGE (16'h0001)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_cnt        (i_cnt),
    .i_cnt_done   (i_cnt_done),
    .i_init       (i_init),
    .i_trap       (i_trap),
    .i_mret       (i_mret),
    .i_e_op       (i_e_op),
    .i_ebreak     (i_ebreak),
    .i_mem_op     (i_mem_op),
    .i_mem_cmd    (i_mem_cmd),
    .i_csr_sel    (i_csr_sel),
    .i_csr_en     (i_csr_en),
    .i_csr_source (i_csr_source),
    .i_csr_d      (i_csr_d),
    .i_msip       (i_msip),
    .i_mtip       (i_mtip),
    .i_meip       (i_meip),
    .i_irq        (i_irq),
    .o_csr_in     (o_csr_in),
    .o_q          (o_q),
    .o_new_irq    (o_new_irq)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model state. Lines vector is {irq1, irq0, meip, mtip, msip}; irq0 is edge-latched.
  bit          m_mie_b, m_mpie, m_new, m_pend0;
  logic [31:0] m_mie, m_mcause;
  logic [4:0]  m_code;
  logic [4:0]  m_lines;
  logic [4:0]  prio [5] = '{5'd11, 5'd3, 5'd7, 5'd16, 5'd17};
  logic [31:0] rd, dummy;

  function automatic logic [31:0] m_mip();
    logic [31:0] r = '0;
    r[3]  = m_lines[0];
    r[7]  = m_lines[1];
    r[11] = m_lines[2];
    r[16] = m_pend0;
    r[17] = m_lines[4];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
      2'd1:    return m_mie;
      2'd2:    return m_mip();
      default: return m_mcause;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie_b = 0; m_mpie = 0; m_new = 0; m_pend0 = 0;
    m_mie = '0; m_mcause = '0; m_code = '0;
  endtask

  task automatic drive_idle();
    i_en = 0; i_cnt = '0; i_cnt_done = 0; i_init = 0; i_trap = 0; i_mret = 0;
    i_e_op = 0; i_ebreak = 0; i_mem_op = 0; i_mem_cmd = 0;
    i_csr_en = 0; i_csr_sel = '0; i_csr_source = '0; i_csr_d = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic set_lines(input logic [4:0] v);
    if (v[3] && !m_lines[3]) m_pend0 = 1;
    m_lines = v;
    {i_irq[1], i_irq[0], i_meip, i_mtip, i_msip} = v;
    tick(2);
  endtask

  task automatic pulse_irq0();
    if (!m_lines[3]) m_pend0 = 1;
    i_irq[0] = 1'b1;
    tick(1);
    i_irq[0] = 1'b0;
    tick(1);
  endtask

  // One full 32-cycle instruction plus the corresponding model update.
  task automatic instr(input bit csr_en, input logic [1:0] sel, input logic [1:0] src,
                       input logic [31:0] d, input bit init, input bit trap, input bit mret,
                       input bit e_op, input bit ebreak, input bit mem_op, input bit mem_cmd,
                       output logic [31:0] q_word);
    logic [31:0] cw, old, w;
    bit          was_new;
    old = m_read(sel);
    i_csr_en = csr_en; i_csr_sel = sel; i_csr_source = src; i_init = init;
    i_trap = trap; i_mret = mret; i_e_op = e_op; i_ebreak = ebreak;
    i_mem_op = mem_op; i_mem_cmd = mem_cmd;
    for (int c = 0; c < 32; c++) begin
      i_en = 1; i_cnt = 5'(c); i_cnt_done = (c == 31); i_csr_d = d[c];
      @(negedge i_clk);
      q_word[c] = o_q;
      cw[c]     = o_csr_in;
      @(posedge i_clk); #1;
    end
    drive_idle();
    if (csr_en) begin
      case (src)
        2'd1:    w = d;
        2'd2:    w = old | d;
        2'd3:    w = old & ~d;
        default: w = old;
      endcase
      chk("csr_read", q_word, old);
      chk("csr_in", cw, w);
      if (!trap) begin
        case (sel)
          2'd0: begin m_mie_b = w[3]; m_mpie = w[7]; end
          2'd1: m_mie = w & 32'h0003_0888;
          2'd3: m_mcause = w & 32'h8000_001F;
          default: ;
        endcase
      end
    end
    was_new = m_new;
    if (trap) begin
      m_new = 0;
    end else if (!init && !m_new && m_mie_b && ((m_mip() & m_mie) != 0)) begin
      m_new = 1;
      for (int i = 4; i >= 0; i--)
        if ((m_mip() & m_mie) & (32'd1 << prio[i])) m_code = prio[i];
    end
    if (trap) begin
      if (was_new) m_mcause = 32'h8000_0000 | 32'(m_code);
      else if (mem_op) m_mcause = mem_cmd ? 32'd6 : 32'd4;
      else if (e_op) m_mcause = ebreak ? 32'd3 : 32'd11;
      else m_mcause = 32'd0;
      if (was_new && m_code == 5'd16) m_pend0 = 0;
      m_mpie = m_mie_b;
      m_mie_b = 0;
    end else if (mret) begin
      m_mie_b = m_mpie;
      m_mpie = 1;
    end
    chk("new_irq", 32'(o_new_irq), 32'(m_new));
  endtask

  task automatic csr(input logic [1:0] sel, input logic [1:0] src, input logic [31:0] d,
                     output logic [31:0] q_word);
    instr(1, sel, src, d, 0, 0, 0, 0, 0, 0, 0, q_word);
  endtask

  task automatic plain(input bit init);
    instr(0, 2'd0, 2'd0, '0, init, 0, 0, 0, 0, 0, 0, dummy);
  endtask

  task automatic trap_i(input bit e_op, input bit ebreak, input bit mem_op, input bit mem_cmd);
    instr(0, 2'd0, 2'd0, '0, 0, 1, 0, e_op, ebreak, mem_op, mem_cmd, dummy);
  endtask

  task automatic mret_i();
    instr(0, 2'd0, 2'd0, '0, 0, 0, 1, 0, 0, 0, 0, dummy);
  endtask

  initial begin
    drive_idle();
    i_msip = 0; i_mtip = 0; i_meip = 0; i_irq = '0; m_lines = '0;
    model_reset();
    i_rst = 1;
    tick(3);
    i_rst = 0;

    // Reset state
    chk("rst_new_irq", 32'(o_new_irq), 32'd0);
    csr(2'd0, 2'd0, '0, rd); chk("rst_mstatus", rd, 32'd0);
    csr(2'd1, 2'd0, '0, rd); chk("rst_mie", rd, 32'd0);
    csr(2'd2, 2'd0, '0, rd); chk("rst_mip", rd, 32'd0);
    csr(2'd3, 2'd0, '0, rd); chk("rst_mcause", rd, 32'd0);

    // Timer interrupt accepted and trapped
    csr(2'd0, 2'd2, 32'h8, dummy);
    csr(2'd1, 2'd2, 32'h80, dummy);
    set_lines(5'b00010);
    plain(0);
    chk("mti_accept", 32'(o_new_irq), 32'd1);
    trap_i(0, 0, 0, 0);
    csr(2'd3, 2'd0, '0, rd); chk("mti_mcause", rd, 32'h8000_0007);
    csr(2'd0, 2'd0, '0, rd); chk("mti_mstatus", rd, 32'h0000_0080);

    // Edge line pulse latched while MIE=0, taken later, cleared by the trap
    set_lines(5'b00000);
    pulse_irq0();
    csr(2'd2, 2'd0, '0, rd); chk("edge_mip", rd, 32'h0001_0000);
    csr(2'd1, 2'd2, 32'h0001_0000, dummy);
    mret_i();
    plain(0);
    trap_i(0, 0, 0, 0);
    csr(2'd3, 2'd0, '0, rd); chk("edge_mcause", rd, 32'h8000_0010);
    csr(2'd2, 2'd0, '0, rd); chk("edge_mip_clr", rd, 32'h0);

    // Fixed priority: MEI, then MSI once MEIE is cleared
    csr(2'd1, 2'd2, 32'h888, dummy);
    set_lines(5'b01111);
    mret_i();
    plain(0);
    trap_i(0, 0, 0, 0);
    csr(2'd3, 2'd0, '0, rd); chk("prio_mei", rd, 32'h8000_000B);
    csr(2'd1, 2'd3, 32'h800, dummy);
    mret_i();
    plain(0);
    trap_i(0, 0, 0, 0);
    csr(2'd3, 2'd0, '0, rd); chk("prio_msi", rd, 32'h8000_0003);
    set_lines(5'b00000);
    csr(2'd1, 2'd3, 32'hFFFF_FFFF, dummy);

    // ecall with interrupts enabled but nothing pending, then mret
    mret_i();
    trap_i(1, 0, 0, 0);
    chk("ecall_no_irq", 32'(o_new_irq), 32'd0);
    csr(2'd3, 2'd0, '0, rd); chk("ecall_mcause", rd, 32'd11);
    mret_i();
    csr(2'd0, 2'd0, '0, rd); chk("mret_mstatus", rd, 32'h0000_0088);

    // Accepted code is frozen even after the request drops
    csr(2'd1, 2'd2, 32'h80, dummy);
    set_lines(5'b00010);
    plain(0);
    set_lines(5'b00000);
    plain(0);
    chk("held_new_irq", 32'(o_new_irq), 32'd1);
    trap_i(0, 0, 0, 0);
    csr(2'd3, 2'd0, '0, rd); chk("held_mcause", rd, 32'h8000_0007);

    // Reset in the middle of a trapping instruction
    mret_i();
    set_lines(5'b00010);
    plain(0);
    set_lines(5'b00000);
    i_trap = 1;
    for (int c = 0; c < 12; c++) begin
      i_en = 1; i_cnt = 5'(c);
      tick(1);
    end
    drive_idle();
    i_rst = 1;
    tick(2);
    i_rst = 0;
    model_reset();
    chk("midrst_new_irq", 32'(o_new_irq), 32'd0);
    csr(2'd0, 2'd0, '0, rd); chk("midrst_mstatus", rd, 32'd0);
    csr(2'd1, 2'd0, '0, rd); chk("midrst_mie", rd, 32'd0);
    csr(2'd2, 2'd0, '0, rd); chk("midrst_mip", rd, 32'd0);
    csr(2'd3, 2'd0, '0, rd); chk("midrst_mcause", rd, 32'd0);

    // Randomized instruction stream against the model
    for (int it = 0; it < 400; it++) begin
      int unsigned r, k;
      if ($urandom_range(0, 3) == 0) set_lines(5'($urandom_range(0, 31)));
      r = $urandom_range(0, 9);
      if (m_new && r < 3) begin
        trap_i($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);
      end else if (r <= 3) begin
        csr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, dummy);
      end else if (r == 4) begin
        k = $urandom_range(0, 4);
        trap_i(k == 1 || k == 2, k == 2, k == 3 || k == 4, k == 4);
      end else if (r == 5) begin
        mret_i();
      end else begin
        plain($urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
